// File: rtl/flash_pkg.sv
// Shared definitions for the flash word reader: state encoding, default timings
// and the flash address width also used by the ROM loader.
package flash_pkg;

    typedef enum logic [2:0] {
        StRstHold,
        StRstRec,
        StIdle,
        StRdHi,
        StRdLo
    } flash_state_e;

    localparam int unsigned ACCESS_CYCLES_DEFAULT = 6;
    localparam int unsigned RESET_CYCLES_DEFAULT  = 32;
    localparam int unsigned FLASH_AW              = 23;

    // Flash words are 16 bits, so the read always starts at the even byte.
    function automatic logic [FLASH_AW-1:0] word_addr(input logic [FLASH_AW-1:0] byte_addr);
        return byte_addr & ~{{(FLASH_AW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/flash_access_timer.sv
// Clearable 8-bit phase counter; done is high on the last clock of a phase
// (count == limit-1), so the count never wraps.
module flash_access_timer (
    input  logic       iclk,
    input  logic       ireset,
    input  logic       iclear,
    input  logic [7:0] ilimit,
    output logic       odone
);

    logic [7:0] count_q;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            count_q <= '0;
        end else if (iclear) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + 8'd1;
        end
    end

    assign odone = (count_q == ilimit - 8'd1);

endmodule

// File: rtl/flash_word_reader.sv
// Toggle-handshake responder that reads a big-endian 16-bit word from the 8-bit
// parallel NOR flash as two byte accesses; also sequences the flash reset pin.
module flash_word_reader
    import flash_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT,
    parameter int unsigned RESET_CYCLES  = RESET_CYCLES_DEFAULT
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic [FLASH_AW-1:0] ifl_addr,
    input  logic                ifl_req,
    output logic                ofl_ack,
    output logic [15:0]         ofl_data,
    output logic                oready,
    output logic [FLASH_AW-1:0] oflash_addr,
    input  logic [7:0]          iflash_dq,
    output logic                oflash_ce_n,
    output logic                oflash_oe_n,
    output logic                oflash_we_n,
    output logic                oflash_rst_n,
    output logic                oflash_wp_n
);

    flash_state_e state_q;
    logic [7:0]   hi_q;
    logic         timer_clear;
    logic         timer_done;
    logic [7:0]   timer_limit;

    // Counter is held at zero in idle so every read phase starts from a fresh count.
    assign timer_clear = timer_done | (state_q == StIdle);
    assign timer_limit = (state_q == StRstHold || state_q == StRstRec) ?
                         8'(RESET_CYCLES) : 8'(ACCESS_CYCLES);

    flash_access_timer u_timer (
        .iclk   (iclk),
        .ireset (ireset),
        .iclear (timer_clear),
        .ilimit (timer_limit),
        .odone  (timer_done)
    );

    assign oflash_we_n = 1'b1;
    assign oflash_wp_n = 1'b0;

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state_q      <= StRstHold;
            hi_q         <= '0;
            ofl_ack      <= 1'b0;
            ofl_data     <= '0;
            oready       <= 1'b0;
            oflash_addr  <= '0;
            oflash_ce_n  <= 1'b1;
            oflash_oe_n  <= 1'b1;
            oflash_rst_n <= 1'b0;
        end else begin
            unique case (state_q)
                StRstHold: begin
                    if (timer_done) begin
                        oflash_rst_n <= 1'b1;
                        state_q      <= StRstRec;
                    end
                end
                StRstRec: begin
                    if (timer_done) begin
                        oready  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                StIdle: begin
                    if (ifl_req != ofl_ack) begin
                        oflash_addr <= word_addr(ifl_addr);
                        oflash_ce_n <= 1'b0;
                        oflash_oe_n <= 1'b0;
                        state_q     <= StRdHi;
                    end
                end
                StRdHi: begin
                    if (timer_done) begin
                        hi_q           <= iflash_dq;
                        oflash_addr[0] <= 1'b1;
                        state_q        <= StRdLo;
                    end
                end
                StRdLo: begin
                    if (timer_done) begin
                        ofl_data    <= {hi_q, iflash_dq};
                        ofl_ack     <= ~ofl_ack;
                        oflash_ce_n <= 1'b1;
                        oflash_oe_n <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StRstHold;
            endcase
        end
    end

endmodule
